// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: operand/result timing
// encodings, register-file indexing and default multiply/divide latencies.
package stall_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int TUSE_W   = 2;
  localparam int TNEW_W   = 2;
  localparam int MD_CNT_W = 4;
  localparam int STALL_W  = 32;

  localparam logic [TUSE_W-1:0]  TUSE_NONE = 2'd3;
  localparam logic [REG_W-1:0]   REG_ZERO  = 5'd0;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [STALL_W-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/stall_ctrl_mdcnt.sv
// Multiply/divide busy scheduler: loads the operation latency on a start
// and counts down to zero; busy while the count is non-zero.
module stall_ctrl_mdcnt
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_i,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  // A start arriving while already counting is dropped; decode never issues one.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && (cnt_q == 4'd0)) begin
      cnt_d = is_div_i ? DIV_LD : MULT_LD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/stall_ctrl.sv
// Decode-stage hazard controller: Tuse/Tnew register dependency checks plus
// MDU busy interlock, driving PC/D hold, E bubble and a stall-cycle counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic [REG_W-1:0]   D_rs_addr,
  input  logic [REG_W-1:0]   D_rt_addr,
  input  logic [TUSE_W-1:0]  D_rs_tuse,
  input  logic [TUSE_W-1:0]  D_rt_tuse,
  input  logic               D_is_md,
  input  logic [REG_W-1:0]   E_wa,
  input  logic [TNEW_W-1:0]  E_tnew,
  input  logic [REG_W-1:0]   M_wa,
  input  logic [TNEW_W-1:0]  M_tnew,
  input  logic               E_md_start,
  input  logic               E_md_is_div,
  output logic               STALL_EN_N,
  output logic               E_FLUSH,
  output logic               md_busy,
  output logic [STALL_W-1:0] stall_cycles
);

  logic rs_hz_s;
  logic rt_hz_s;
  logic md_hz_s;
  logic stall_s;

  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;

  stall_ctrl_mdcnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdcnt (
    .clk      (clk),
    .rst_i    (RESET),
    .start_i  (E_md_start),
    .is_div_i (E_md_is_div),
    .busy_o   (md_busy)
  );

  // A producer stalls the consumer only if its result arrives later than needed.
  always_comb begin
    rs_hz_s = (D_rs_addr != REG_ZERO) && (D_rs_tuse != TUSE_NONE) &&
              (((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
               ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse)));
    rt_hz_s = (D_rt_addr != REG_ZERO) && (D_rt_tuse != TUSE_NONE) &&
              (((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
               ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse)));
    md_hz_s = D_is_md && (E_md_start || md_busy);
    if (RESET) begin
      stall_s = 1'b0;
    end else begin
      stall_s = rs_hz_s || rt_hz_s || md_hz_s;
    end
  end

  assign STALL_EN_N = ~stall_s;
  assign E_FLUSH    = stall_s;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
